// File: rtl/register_ctrl_pkg.sv
// Shared encodings for the multi-mode register and its command sequencer:
// register opcodes, sequencer command ops and sequencer FSM states.
package register_ctrl_pkg;

    localparam logic [2:0] CTRL_NONE                = 3'd0;
    localparam logic [2:0] CTRL_CLR                 = 3'd1;
    localparam logic [2:0] CTRL_PARALLEL_LOAD       = 3'd2;
    localparam logic [2:0] CTRL_SERIAL_MSB_LOAD     = 3'd3;
    localparam logic [2:0] CTRL_SERIAL_LSB_LOAD     = 3'd4;
    localparam logic [2:0] CTRL_SHIFT_LOGICAL_LEFT  = 3'd5;
    localparam logic [2:0] CTRL_SHIFT_LOGICAL_RIGHT = 3'd6;

    typedef enum logic [1:0] {
        OP_CLR        = 2'd0,
        OP_PARALLEL   = 2'd1,
        OP_SERIAL_MSB = 2'd2,
        OP_SERIAL_LSB = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/register_cmd_sequencer.sv
// Command sequencer: turns clear / parallel / serial-load commands into the
// per-cycle ctrl and data stream consumed by the multi-mode register.
module register_cmd_sequencer
    import register_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [2:0]       ctrl,
    output logic             serial_data_output,
    output logic [WIDTH-1:0] parallel_data_output,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    function automatic logic [CNT_W-1:0] len_eff(input logic [CNT_W-1:0] l);
        return (l == '0 || l > FULL_LEN) ? FULL_LEN : l;
    endfunction

    function automatic logic pick(input logic [WIDTH-1:0] d,
                                  input logic [CNT_W-1:0] i);
        logic [WIDTH-1:0] t;
        t = d >> i;
        return t[0];
    endfunction

    seq_state_e       state;
    cmd_op_e          op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;

    logic             accept;
    cmd_op_e          op_in;
    logic [CNT_W-1:0] len_in;
    logic             first_bit;
    logic [CNT_W-1:0] nk;
    logic [CNT_W-1:0] nidx;
    logic             last;

    assign accept = cmd_valid & cmd_ready;
    assign op_in  = cmd_op_e'(cmd_op);
    assign len_in = len_eff(cmd_len);

    // MSB-insert register needs the field LSB first; LSB-insert needs it MSB first
    assign first_bit = pick(cmd_data,
                            (op_in == OP_SERIAL_MSB) ? '0 : len_in - ONE);
    assign nk   = cnt + ONE;
    assign nidx = (op_q == OP_SERIAL_MSB) ? nk : len_q - ONE - nk;
    assign last = (cnt == len_q - ONE);

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state                <= S_IDLE;
            op_q                 <= OP_CLR;
            data_q               <= '0;
            cnt                  <= '0;
            len_q                <= '0;
            cmd_ready            <= 1'b0;
            ctrl                 <= CTRL_NONE;
            serial_data_output   <= 1'b0;
            parallel_data_output <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    state              <= S_IDLE;
                    ctrl               <= CTRL_NONE;
                    serial_data_output <= 1'b0;
                    busy               <= 1'b0;
                    done               <= 1'b0;
                    cmd_ready          <= 1'b1;
                    if (accept) begin
                        data_q    <= cmd_data;
                        op_q      <= op_in;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        unique case (op_in)
                            OP_CLR: begin
                                state <= S_ISSUE;
                                ctrl  <= CTRL_CLR;
                            end
                            OP_PARALLEL: begin
                                state                <= S_ISSUE;
                                ctrl                 <= CTRL_PARALLEL_LOAD;
                                parallel_data_output <= cmd_data;
                            end
                            default: begin
                                state              <= S_SHIFT;
                                cnt                <= '0;
                                len_q              <= len_in;
                                serial_data_output <= first_bit;
                                ctrl <= (op_in == OP_SERIAL_MSB) ?
                                        CTRL_SERIAL_MSB_LOAD :
                                        CTRL_SERIAL_LSB_LOAD;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    state     <= S_DONE;
                    ctrl      <= CTRL_NONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                end
                S_SHIFT: begin
                    if (last) begin
                        state              <= S_DONE;
                        ctrl               <= CTRL_NONE;
                        serial_data_output <= 1'b0;
                        busy               <= 1'b0;
                        done               <= 1'b1;
                        cmd_ready          <= 1'b1;
                    end else begin
                        cnt                <= nk;
                        serial_data_output <= pick(data_q, nidx);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
